// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline stall/flush sequencer.
// The helper below encodes the rule that register 0 never participates in a hazard.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    HALT     = 2'd0,
    RUN      = 2'd1,
    MEM_WAIT = 2'd2,
    ERROR    = 2'd3
  } pipe_state_e;

  localparam logic [4:0] REG_ZERO = 5'd0;

  function automatic logic reg_hit(input logic [4:0] dst, input logic [4:0] src);
    return (dst != REG_ZERO) && (dst == src);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         inc_i,
  output logic [W-1:0] count_o
);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      count_o <= '0;
    end else if (inc_i && (count_o != {W{1'b1}})) begin
      count_o <= count_o + W'(1);
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use and branch-operand
// stalls, IF/ID flush on redirect, whole-pipe freeze on outstanding data memory access.
//
// Handshake: the data memory access completes on any cycle where mem_req_o and
// mem_ready_i are both high; mem_req_o stays high from the first unready cycle until
// that completion, and the pipeline advances in the completion cycle itself.
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             start_i,
  input  logic [4:0]       id_rs_i,
  input  logic [4:0]       id_rt_i,
  input  logic             id_uses_rt_i,
  input  logic             id_branch_i,
  input  logic             id_jump_i,
  input  logic             branch_eq_i,
  input  logic             ex_memread_i,
  input  logic             ex_regwrite_i,
  input  logic [4:0]       ex_dst_i,
  input  logic             mem_memread_i,
  input  logic [4:0]       mem_dst_i,
  input  logic             mem_access_i,
  input  logic             mem_ready_i,
  output logic             mem_req_o,
  output logic             pc_write_o,
  output logic             ifid_write_o,
  output logic             ifid_flush_o,
  output logic             idex_bubble_o,
  output logic             pipe_freeze_o,
  output logic             err_o,
  output logic [CNT_W-1:0] lu_stalls_o,
  output logic [CNT_W-1:0] br_flushes_o,
  output logic [CNT_W-1:0] mem_waits_o,
  output pipe_state_e      state_o
);

  localparam int TW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);
  localparam logic [TW-1:0] WAIT_LAST = TW'(MEM_TIMEOUT - 1);

  pipe_state_e   state_q, state_d;
  logic [TW-1:0] wait_q, wait_d;
  logic          advance;
  logic          lu_hazard, br_hazard, redirect;
  logic          lu_inc, br_inc, mw_inc;

  assign lu_hazard = ex_memread_i &
                     (reg_hit(ex_dst_i, id_rs_i) | (id_uses_rt_i & reg_hit(ex_dst_i, id_rt_i)));
  assign br_hazard = id_branch_i &
                     ((ex_regwrite_i & (reg_hit(ex_dst_i, id_rs_i) | reg_hit(ex_dst_i, id_rt_i))) |
                      (mem_memread_i & (reg_hit(mem_dst_i, id_rs_i) | reg_hit(mem_dst_i, id_rt_i))));
  assign redirect  = (id_branch_i & branch_eq_i) | id_jump_i;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= HALT;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    wait_d        = wait_q;
    advance       = 1'b0;
    mem_req_o     = 1'b0;
    pc_write_o    = 1'b0;
    ifid_write_o  = 1'b0;
    ifid_flush_o  = 1'b0;
    idex_bubble_o = 1'b0;
    pipe_freeze_o = 1'b0;
    err_o         = 1'b0;
    lu_inc        = 1'b0;
    br_inc        = 1'b0;
    mw_inc        = 1'b0;

    case (state_q)
      HALT: begin
        pipe_freeze_o = 1'b1;
        ifid_flush_o  = 1'b1;
        if (start_i) state_d = RUN;
      end
      RUN: begin
        mem_req_o = mem_access_i;
        if (mem_access_i && !mem_ready_i) begin
          pipe_freeze_o = 1'b1;
          mw_inc        = 1'b1;
          state_d       = MEM_WAIT;
          wait_d        = '0;
        end else begin
          advance = 1'b1;
        end
      end
      MEM_WAIT: begin
        mem_req_o = 1'b1;
        if (mem_ready_i) begin
          advance = 1'b1;
          state_d = RUN;
        end else begin
          pipe_freeze_o = 1'b1;
          mw_inc        = 1'b1;
          if (wait_q == WAIT_LAST) state_d = ERROR;
          else                     wait_d  = wait_q + TW'(1);
        end
      end
      ERROR: begin
        pipe_freeze_o = 1'b1;
        err_o         = 1'b1;
      end
      default: state_d = HALT;
    endcase

    // A stall holds PC and IF/ID and wins over any redirect in the same cycle.
    if (advance) begin
      if (lu_hazard || br_hazard) begin
        idex_bubble_o = 1'b1;
        lu_inc        = 1'b1;
      end else begin
        pc_write_o   = 1'b1;
        ifid_write_o = 1'b1;
        ifid_flush_o = redirect;
        br_inc       = redirect;
      end
    end

    // Asserted reset overrides everything so an open request drops at once.
    if (!rst_n_i) begin
      mem_req_o     = 1'b0;
      pc_write_o    = 1'b0;
      ifid_write_o  = 1'b0;
      ifid_flush_o  = 1'b1;
      idex_bubble_o = 1'b0;
      pipe_freeze_o = 1'b0;
      err_o         = 1'b0;
    end
  end

  assign state_o = state_q;

  sat_counter #(.W(CNT_W)) u_lu_cnt (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .inc_i   (lu_inc),
    .count_o (lu_stalls_o)
  );

  sat_counter #(.W(CNT_W)) u_br_cnt (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .inc_i   (br_inc),
    .count_o (br_flushes_o)
  );

  sat_counter #(.W(CNT_W)) u_mw_cnt (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .inc_i   (mw_inc),
    .count_o (mem_waits_o)
  );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: directed scenarios with literal expectations,
// then random traffic checked every cycle against a behavioural model.
module tb_pipeline_hazard_ctrl;
  import pipe_ctrl_pkg::*;

  localparam int CW   = 4;
  localparam int TMO  = 4;
  localparam int OW   = 7 + 3 * CW;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk_i = 1'b0;
  logic          rst_n_i = 1'b0;
  logic          start_i = 1'b0;
  logic [4:0]    id_rs_i = '0, id_rt_i = '0, ex_dst_i = '0, mem_dst_i = '0;
  logic          id_uses_rt_i = 1'b0, id_branch_i = 1'b0, id_jump_i = 1'b0, branch_eq_i = 1'b0;
  logic          ex_memread_i = 1'b0, ex_regwrite_i = 1'b0, mem_memread_i = 1'b0;
  logic          mem_access_i = 1'b0, mem_ready_i = 1'b0;
  logic          mem_req_o, pc_write_o, ifid_write_o, ifid_flush_o;
  logic          idex_bubble_o, pipe_freeze_o, err_o;
  logic [CW-1:0] lu_stalls_o, br_flushes_o, mem_waits_o;
  pipe_state_e   state_o;

  pipeline_hazard_ctrl #(.CNT_W(CW), .MEM_TIMEOUT(TMO)) dut (
    .clk_i         (clk_i),
    .rst_n_i       (rst_n_i),
    .start_i       (start_i),
    .id_rs_i       (id_rs_i),
    .id_rt_i       (id_rt_i),
    .id_uses_rt_i  (id_uses_rt_i),
    .id_branch_i   (id_branch_i),
    .id_jump_i     (id_jump_i),
    .branch_eq_i   (branch_eq_i),
    .ex_memread_i  (ex_memread_i),
    .ex_regwrite_i (ex_regwrite_i),
    .ex_dst_i      (ex_dst_i),
    .mem_memread_i (mem_memread_i),
    .mem_dst_i     (mem_dst_i),
    .mem_access_i  (mem_access_i),
    .mem_ready_i   (mem_ready_i),
    .mem_req_o     (mem_req_o),
    .pc_write_o    (pc_write_o),
    .ifid_write_o  (ifid_write_o),
    .ifid_flush_o  (ifid_flush_o),
    .idex_bubble_o (idex_bubble_o),
    .pipe_freeze_o (pipe_freeze_o),
    .err_o         (err_o),
    .lu_stalls_o   (lu_stalls_o),
    .br_flushes_o  (br_flushes_o),
    .mem_waits_o   (mem_waits_o),
    .state_o       (state_o)
  );

  // Clock: rising edges at 5, 15, ...; inputs change on falling edges.
  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad   = 0;
  logic [OW-1:0] exp_q[$];

  // Behavioural model: "started", "waiting on memory", "dead after timeout".
  bit m_started = 0, m_waiting = 0, m_dead = 0;
  int m_wait = 0, m_lu = 0, m_br = 0, m_mw = 0;

  function automatic int sat(input int v);
    return (v > CMAX) ? CMAX : v;
  endfunction

  function automatic bit src_match(input logic [4:0] d, input logic [4:0] s);
    return (d != 5'd0) && (d == s);
  endfunction

  function automatic bit m_stall();
    bit lu, br;
    lu = ex_memread_i && (src_match(ex_dst_i, id_rs_i) ||
                          (id_uses_rt_i && src_match(ex_dst_i, id_rt_i)));
    br = id_branch_i &&
         ((ex_regwrite_i && (src_match(ex_dst_i, id_rs_i) || src_match(ex_dst_i, id_rt_i))) ||
          (mem_memread_i && (src_match(mem_dst_i, id_rs_i) || src_match(mem_dst_i, id_rt_i))));
    return lu || br;
  endfunction

  function automatic bit m_mem_block();
    return m_waiting ? !mem_ready_i : (mem_access_i && !mem_ready_i);
  endfunction

  function automatic logic [OW-1:0] model_out();
    logic mreq, pcw, ifw, fl, bub, frz, err;
    {mreq, pcw, ifw, fl, bub, frz, err} = '0;
    if (!rst_n_i) begin
      fl = 1'b1;
    end else if (m_dead) begin
      frz = 1'b1;
      err = 1'b1;
    end else if (!m_started) begin
      frz = 1'b1;
      fl  = 1'b1;
    end else begin
      mreq = m_waiting || mem_access_i;
      if (m_mem_block()) begin
        frz = 1'b1;
      end else if (m_stall()) begin
        bub = 1'b1;
      end else begin
        pcw = 1'b1;
        ifw = 1'b1;
        fl  = (id_branch_i && branch_eq_i) || id_jump_i;
      end
    end
    return {mreq, pcw, ifw, fl, bub, frz, err, CW'(m_lu), CW'(m_br), CW'(m_mw)};
  endfunction

  always @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      m_started = 0; m_waiting = 0; m_dead = 0;
      m_wait = 0; m_lu = 0; m_br = 0; m_mw = 0;
    end else if (!m_dead) begin
      if (!m_started) begin
        m_started = start_i;
      end else if (m_mem_block()) begin
        m_mw = sat(m_mw + 1);
        if (!m_waiting) begin
          m_waiting = 1;
          m_wait    = 0;
        end else begin
          m_wait++;
          if (m_wait == TMO) m_dead = 1;
        end
      end else begin
        m_waiting = 0;
        if (m_stall())                                       m_lu = sat(m_lu + 1);
        else if ((id_branch_i && branch_eq_i) || id_jump_i) m_br = sat(m_br + 1);
      end
    end
  end

  // Scoreboard: model expectation queued, then compared against the DUT each cycle.
  always @(negedge clk_i) begin
    #1;
    exp_q.push_back(model_out());
  end

  always @(negedge clk_i) begin
    logic [OW-1:0] got, exp;
    #2;
    got = {mem_req_o, pc_write_o, ifid_write_o, ifid_flush_o, idex_bubble_o, pipe_freeze_o,
           err_o, lu_stalls_o, br_flushes_o, mem_waits_o};
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL model_queue t=%0t got=empty required=entry", $time);
    end else begin
      exp = exp_q.pop_front();
      if (got !== exp) begin
        bad++;
        $display("FAIL outputs t=%0t got=%h required=%h", $time, got, exp);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s t=%0t got=%0h required=%0h", name, $time, got, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk_i);
  endtask

  task automatic set_idle();
    id_rs_i = '0; id_rt_i = '0; ex_dst_i = '0; mem_dst_i = '0;
    id_uses_rt_i = 0; id_branch_i = 0; id_jump_i = 0; branch_eq_i = 0;
    ex_memread_i = 0; ex_regwrite_i = 0; mem_memread_i = 0;
    mem_access_i = 0; mem_ready_i = 0;
  endtask

  initial begin
    set_idle();
    cyc(); #3;
    chk("rst_flush", 32'(ifid_flush_o), 1);
    chk("rst_pc_write", 32'(pc_write_o), 0);
    chk("rst_freeze", 32'(pipe_freeze_o), 0);
    chk("rst_state", 32'(state_o), 32'(HALT));
    chk("rst_counters", 32'({lu_stalls_o, br_flushes_o, mem_waits_o}), 0);

    // Start on the third cycle after reset release.
    cyc(); rst_n_i = 1; #3;
    chk("halt_pc_write", 32'(pc_write_o), 0);
    chk("halt_freeze", 32'(pipe_freeze_o), 1);
    cyc(); #3 chk("halt_flush", 32'(ifid_flush_o), 1);
    cyc(); start_i = 1; #3 chk("halt_cycle3", 32'(pc_write_o), 0);
    cyc(); start_i = 0; #3;
    chk("run_cycle4", 32'(pc_write_o), 1);
    chk("run_state", 32'(state_o), 32'(RUN));

    // lw $2 in EX, add $3,$2,$4 in ID.
    cyc(); ex_memread_i = 1; ex_regwrite_i = 1; ex_dst_i = 5'd2;
    id_rs_i = 5'd2; id_rt_i = 5'd4; id_uses_rt_i = 1; #3;
    chk("lu_bubble", 32'(idex_bubble_o), 1);
    chk("lu_pc_hold", 32'(pc_write_o), 0);
    cyc(); set_idle(); id_rs_i = 5'd2; id_rt_i = 5'd4; id_uses_rt_i = 1; #3;
    chk("lu_count", 32'(lu_stalls_o), 1);
    chk("lu_released", 32'(idex_bubble_o), 0);

    // beq $5,$6 with $5 still being produced in EX, then resolved equal.
    cyc(); set_idle(); id_branch_i = 1; id_rs_i = 5'd5; id_rt_i = 5'd6; id_uses_rt_i = 1;
    ex_regwrite_i = 1; ex_dst_i = 5'd5; branch_eq_i = 1; #3;
    chk("br_stall", 32'(idex_bubble_o), 1);
    chk("br_no_flush", 32'(ifid_flush_o), 0);
    cyc(); ex_regwrite_i = 0; ex_dst_i = 5'd0; #3;
    chk("br_flush", 32'(ifid_flush_o), 1);
    chk("br_pc_write", 32'(pc_write_o), 1);
    chk("br_lu_count", 32'(lu_stalls_o), 2);
    cyc(); set_idle(); #3 chk("br_count", 32'(br_flushes_o), 1);

    // Memory not ready for three cycles.
    cyc(); mem_access_i = 1; mem_ready_i = 0; #3 chk("mw_freeze1", 32'(pipe_freeze_o), 1);
    cyc(); #3;
    chk("mw_freeze2", 32'(pipe_freeze_o), 1);
    chk("mw_state", 32'(state_o), 32'(MEM_WAIT));
    cyc(); #3 chk("mw_freeze3", 32'(pipe_freeze_o), 1);
    cyc(); mem_ready_i = 1; #3;
    chk("mw_done_freeze", 32'(pipe_freeze_o), 0);
    chk("mw_done_pc", 32'(pc_write_o), 1);
    chk("mw_done_req", 32'(mem_req_o), 1);
    cyc(); set_idle(); #3;
    chk("mw_count", 32'(mem_waits_o), 3);
    chk("mw_req_idle", 32'(mem_req_o), 0);

    // Memory never answers: one RUN freeze cycle, TMO wait cycles, then error.
    cyc(); mem_access_i = 1; mem_ready_i = 0;
    repeat (TMO) begin
      cyc(); #3 chk("tmo_not_yet", 32'(err_o), 0);
    end
    cyc(); #3;
    chk("tmo_err", 32'(err_o), 1);
    chk("tmo_pc_hold", 32'(pc_write_o), 0);
    chk("tmo_req_drop", 32'(mem_req_o), 0);
    cyc(); set_idle(); mem_ready_i = 1; start_i = 1; #3;
    chk("tmo_sticky", 32'(err_o), 1);
    chk("tmo_state", 32'(state_o), 32'(ERROR));
    chk("tmo_waits", 32'(mem_waits_o), 8);

    // Reset while a memory access is outstanding.
    cyc(); start_i = 0; rst_n_i = 0;
    cyc(); rst_n_i = 1;
    cyc(); start_i = 1;
    cyc(); start_i = 0; mem_access_i = 1; mem_ready_i = 0;
    cyc(); #3;
    chk("rw_state", 32'(state_o), 32'(MEM_WAIT));
    chk("rw_req", 32'(mem_req_o), 1);
    #1 rst_n_i = 0;
    #1;
    chk("rw_req_drop", 32'(mem_req_o), 0);
    chk("rw_state_halt", 32'(state_o), 32'(HALT));
    chk("rw_counters", 32'({lu_stalls_o, br_flushes_o, mem_waits_o}), 0);

    // Register 0 never hazards; a held hazard saturates the stall counter.
    cyc(); set_idle(); rst_n_i = 1;
    cyc(); start_i = 1;
    cyc(); start_i = 0; ex_memread_i = 1; ex_dst_i = 5'd0; id_uses_rt_i = 1; #3;
    chk("r0_no_stall", 32'(pc_write_o), 1);
    cyc(); ex_dst_i = 5'd7; id_rs_i = 5'd7;
    repeat (20) cyc();
    #3 chk("lu_saturate", 32'(lu_stalls_o), CMAX);

    // Random traffic over a small register range so hazards are frequent.
    for (int i = 0; i < 4000; i++) begin
      cyc();
      rst_n_i       = ($urandom_range(0, 199) != 0);
      start_i       = ($urandom_range(0, 5) == 0);
      id_rs_i       = 5'($urandom_range(0, 3));
      id_rt_i       = 5'($urandom_range(0, 3));
      ex_dst_i      = 5'($urandom_range(0, 3));
      mem_dst_i     = 5'($urandom_range(0, 3));
      id_uses_rt_i  = ($urandom_range(0, 1) == 1);
      id_branch_i   = ($urandom_range(0, 3) == 0);
      id_jump_i     = ($urandom_range(0, 7) == 0);
      branch_eq_i   = ($urandom_range(0, 1) == 1);
      ex_memread_i  = ($urandom_range(0, 2) == 0);
      ex_regwrite_i = ($urandom_range(0, 1) == 1);
      mem_memread_i = ($urandom_range(0, 2) == 0);
      mem_access_i  = ($urandom_range(0, 3) == 0);
      mem_ready_i   = ($urandom_range(0, 3) != 0);
    end

    cyc(); set_idle(); rst_n_i = 1;
    cyc(); #3;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
